// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative ASCON permutation.
//   type_state : 5 x 64-bit lanes, lane 0 is x0
//   fsm_e      : control FSM states
//   RoundConst : round-constant table, index 0 is the first round of p^12
//   ror64      : 64-bit right rotation
package ascon_pack;

  localparam int unsigned NumRounds = 12;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  localparam logic [7:0] RoundConst [NumRounds] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_pc.sv
// ASCON constant addition: XORs the round constant selected by idx into the low byte of x2.
//   state_i : state entering the round
//   idx_i   : round-constant index (0..11)
//   state_o : state with constant added
module ascon_pc
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] idx_i,
  output type_state  state_o
);

  logic [7:0] rc;

  always_comb begin
    rc = 8'h00;
    // idx never leaves 0..11 in use; out-of-table values add nothing
    if (idx_i < 4'(NumRounds)) begin
      rc = RoundConst[idx_i];
    end
    state_o          = state_i;
    state_o[2][7:0]  = state_i[2][7:0] ^ rc;
  end

endmodule

// File: rtl/ascon_pl.sv
// ASCON linear diffusion layer: each lane XORed with two right-rotations of itself.
//   state_i : substituted state
//   state_o : diffused state (end of round)
module ascon_pl
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  assign state_o[0] = state_i[0] ^ ror64(state_i[0], 19) ^ ror64(state_i[0], 28);
  assign state_o[1] = state_i[1] ^ ror64(state_i[1], 61) ^ ror64(state_i[1], 39);
  assign state_o[2] = state_i[2] ^ ror64(state_i[2], 1)  ^ ror64(state_i[2], 6);
  assign state_o[3] = state_i[3] ^ ror64(state_i[3], 10) ^ ror64(state_i[3], 17);
  assign state_o[4] = state_i[4] ^ ror64(state_i[4], 7)  ^ ror64(state_i[4], 41);

endmodule

// File: rtl/ascon_ps.sv
// ASCON substitution layer: the 5-bit S-box applied to all 64 columns {x0,x1,x2,x3,x4}
// (x0 is the column MSB), written in bitsliced form.
//   state_i : constant-added state
//   state_o : substituted state
module ascon_ps
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] y0, y1, y2, y3, y4;

  // Input mixing
  assign x0 = state_i[0] ^ state_i[4];
  assign x1 = state_i[1];
  assign x2 = state_i[2] ^ state_i[1];
  assign x3 = state_i[3];
  assign x4 = state_i[4] ^ state_i[3];

  // Chi-like nonlinear core
  assign t0 = ~x0 & x1;
  assign t1 = ~x1 & x2;
  assign t2 = ~x2 & x3;
  assign t3 = ~x3 & x4;
  assign t4 = ~x4 & x0;

  assign y0 = x0 ^ t1;
  assign y1 = x1 ^ t2;
  assign y2 = x2 ^ t3;
  assign y3 = x3 ^ t4;
  assign y4 = x4 ^ t0;

  // Output mixing
  assign state_o[0] = y0 ^ y4;
  assign state_o[1] = y1 ^ y0;
  assign state_o[2] = ~y2;
  assign state_o[3] = y3 ^ y2;
  assign state_o[4] = y4;

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation: one full round (pc -> ps -> pl) per clock on a 320-bit
// state register. A start in IDLE loads state_i and runs min(rounds_i, 12) rounds using
// the last rounds of the constant table, then pulses done_o for one cycle.
//   clock_i  : clock, rising edge
//   resetb_i : asynchronous reset, active low
//   start_i  : request, honoured only in IDLE
//   rounds_i : round count (values above 12 behave as 12), sampled with start_i
//   state_i  : input state, sampled with start_i
//   state_o  : state register (valid when done_o is high)
//   busy_o   : high while rounds are being applied
//   done_o   : one-cycle completion pulse
module ascon_perm_iter
  import ascon_pack::*;
#(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

  fsm_e       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] remaining_q, remaining_d;

  logic [3:0] rounds_clamped;
  type_state  pc_out, ps_out, pl_out;

  assign rounds_clamped = (rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds_i;

  ascon_pc u_pc (
    .state_i (state_q),
    .idx_i   (idx_q),
    .state_o (pc_out)
  );

  ascon_ps u_ps (
    .state_i (pc_out),
    .state_o (ps_out)
  );

  ascon_pl u_pl (
    .state_i (ps_out),
    .state_o (pl_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          state_d     = state_i;
          // An n-round call uses the final n constants of the table
          idx_d       = 4'(MAX_ROUNDS) - rounds_clamped;
          remaining_d = rounds_clamped;
          fsm_d       = (rounds_clamped != 4'd0) ? StRun : StDone;
        end
      end
      StRun: begin
        state_d     = pl_out;
        idx_d       = idx_q + 4'd1;
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        fsm_d = StIdle;
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      idx_q       <= 4'd0;
      remaining_q <= 4'd0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = (fsm_q == StRun);
  assign done_o  = (fsm_q == StDone);

endmodule

// File: doc/ascon_perm_iter.md
Name: ascon_perm_iter

Overview:
- Sequential ASCON permutation engine: one full round per clock, iterated over a 320-bit state register.
- Each round is constant addition, then the substitution layer (column-wise 5-bit S-box), then linear diffusion.
- Sits directly upstream of and around the substitution layer: it produces the constant-added state that layer consumes, and it takes back that layer's result.
- Serves the mode FSM for p^a (12 rounds) and p^b (6 or 8 rounds) calls.

Parameters:
- MAX_ROUNDS, 12, total round-constant table length; round r of an n-round call uses constant index 12-n+r.

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous reset, active-low
- start_i  in  1  request; accepted only in IDLE
- rounds_i  in  4  number of rounds (0..12), sampled with start
- state_i  in  type_state (5x64)  input state, sampled with start
- state_o  out  type_state (5x64)  state register contents
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (async, resetb_i=0): FSM=IDLE, state register=0, round counter=0, remaining count=0, busy_o=0, done_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start_i=1 at edge N:
  - state_reg <= state_i; idx <= 12 - min(rounds_i,12); remaining <= min(rounds_i,12).
  - rounds_i > 12 is clamped to 12.
  - Next state is RUN if the clamped count > 0, else DONE.
- RUN, each edge:
  - state_reg <= round(state_reg, idx); idx++; remaining--.
  - When remaining was 1, next state is DONE.
  - n rounds update state_reg at edges N+1..N+n.
- DONE: done_o=1 for exactly one cycle, state_o valid, then IDLE at the next edge.
- Latency from accepted start to done_o: n+1 cycles (1 cycle for n=0). Throughput: one request per n+2 cycles.
- start_i in RUN or DONE is ignored; no queuing.
- state_o is always state_reg.
  - It is held unchanged in IDLE and DONE.
  - It changes every cycle in RUN; the consumer samples it only when done_o=1.
- Round definition:
  - Constant addition: x2[7:0] ^= C[idx], with C = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - Substitution: standard ASCON 5-bit S-box on each column {x0[i],x1[i],x2[i],x3[i],x4[i]} (MSB=x0), i=0..63.
  - Linear diffusion, right rotations:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
  - The round is purely combinational between register stages; no internal pipelining.
- Reset asserted mid-RUN: immediate return to IDLE with all registers cleared. No done_o is produced for the aborted call.
- idx is 4 bits and never exceeds 11 while in RUN, so no wrap-around is possible.

Decomposition:
- ascon_pack holds:
  - type_state
  - round-constant array (12 x 8 bits)
  - FSM state enum
- Sub-modules instantiated per round: constant-addition block (pc), the existing substitution layer (ps), linear-diffusion block (pl).
- pc is natural as a separate sub-module named ascon_pc: inputs state and 4-bit idx, output state.

Test Plan:
- Reset mid-run: start, rounds_i=12; deassert resetb_i at cycle 5 -> busy_o=0, done_o=0, state_o=0 immediately; no done_o afterwards.
- Zero-round bypass: rounds_i=0, state_i=arbitrary pattern -> done_o on the cycle after start, state_o==state_i bit-exact.
- Single round on all-zero state: rounds_i=1, state_i=0 -> done_o two cycles after start, with:
  - x1_o=0x0000000096000213
  - x3_o=0x12E580000000004B
  - x4_o=0x0000000000000000
- Full p^12 and p^6 on random states: compare state_o against the team C model. busy_o high exactly 12 (resp. 6) cycles; done_o asserted exactly once per call.
- Start while busy: pulse start_i during RUN and during DONE with different state_i -> ignored; result matches the first request only.
- Clamp: rounds_i=15 -> identical result and timing to rounds_i=12. Back-to-back starts issued on the first IDLE cycle after DONE are accepted.
